// File: rtl/fixfloat_pkg.sv
// Shared definitions for the fixed-point arithmetic unit (fixed_adder,
// fixed_multi_seq): default operand format and the multiplier FSM state type.
package fixfloat_pkg;

  localparam int FIX_INT_W  = 8;
  localparam int FIX_FRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } fix_state_e;

endpackage

// File: rtl/fixed_multi_seq_if.sv
// Operand/result handshake bundle for fixed_multi_seq.
// master = upstream source plus downstream consumer, slave = the multiplier.
interface fixed_multi_seq_if
  import fixfloat_pkg::*;
#(
  parameter int INT_W  = FIX_INT_W,
  parameter int FRAC_W = FIX_FRAC_W
);

  localparam int W = INT_W + FRAC_W;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   num1;
  logic [W-1:0]   num2;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic           overflow;
  logic           precision_lost;
  logic [2*W-1:0] result_full;

  modport master (
    output in_valid, num1, num2, out_ready,
    input  in_ready, out_valid, result, overflow, precision_lost, result_full
  );

  modport slave (
    input  in_valid, num1, num2, out_ready,
    output in_ready, out_valid, result, overflow, precision_lost, result_full
  );

endinterface

// File: rtl/fixed_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// upper accumulator half, then shift the whole accumulator right by one while
// keeping the carry out of the add as the new MSB.
module fixed_shift_add_step #(
  parameter int W = 16
) (
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   mcand_i,
  input  logic           mplr_bit_i,
  output logic [2*W-1:0] acc_o
);

  logic [W:0] sum;

  // Add-and-shift; the carry lands in acc_o[2W-1] so all-ones operands fit.
  always_comb begin
    sum   = {1'b0, acc_i[2*W-1:W]} + {1'b0, (mplr_bit_i ? mcand_i : {W{1'b0}})};
    acc_o = {sum, acc_i[W-1:1]};
  end

endmodule

// File: rtl/fixed_multi_seq.sv
// Sequential unsigned INT_W.FRAC_W fixed-point multiplier, one multiplier bit
// per cycle, valid/ready on both sides. Outputs are registered once per
// operation on DONE entry and held until the next operation completes.
// Optional macro FIXED_MULTI_SAT_EN: saturate result to all ones on overflow.
module fixed_multi_seq
  import fixfloat_pkg::*;
#(
  parameter int INT_W  = FIX_INT_W,
  parameter int FRAC_W = FIX_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  fixed_multi_seq_if.slave  bus
);

  localparam int W     = INT_W + FRAC_W;
  localparam int CNT_W = $clog2(W + 1);

  fix_state_e     state_q, state_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplr_q, mplr_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]   result_q, result_d;
  logic           overflow_q, overflow_d;
  logic           prec_lost_q, prec_lost_d;
  logic [2*W-1:0] full_q, full_d;
  logic [2*W-1:0] acc_step;

  function automatic logic acc_overflow(input logic [2*W-1:0] acc);
    return |acc[2*W-1:W+FRAC_W];
  endfunction

  function automatic logic [W-1:0] map_result(input logic [2*W-1:0] acc);
`ifdef FIXED_MULTI_SAT_EN
    if (acc_overflow(acc)) return {W{1'b1}};
`endif
    return acc[W+FRAC_W-1:FRAC_W];
  endfunction

  fixed_shift_add_step #(.W(W)) u_step (
    .acc_i      (acc_q),
    .mcand_i    (mcand_q),
    .mplr_bit_i (mplr_q[0]),
    .acc_o      (acc_step)
  );

  // Next-state and datapath updates; everything holds unless a branch changes it.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    acc_d       = acc_q;
    count_d     = count_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    prec_lost_d = prec_lost_q;
    full_d      = full_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d = bus.num1;
          mplr_d  = bus.num2;
          acc_d   = '0;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // After W iterations acc holds the exact product; this cycle only
        // registers the mapped outputs from the settled accumulator.
        if (count_q == CNT_W'(W)) begin
          full_d      = acc_q;
          result_d    = map_result(acc_q);
          overflow_d  = acc_overflow(acc_q);
          prec_lost_d = |acc_q[FRAC_W-1:0];
          state_d     = DONE;
        end else begin
          acc_d   = acc_step;
          mplr_d  = mplr_q >> 1;
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers, all cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      prec_lost_q <= 1'b0;
      full_q      <= '0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      prec_lost_q <= prec_lost_d;
      full_q      <= full_d;
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.out_valid      = (state_q == DONE);
  assign bus.result         = result_q;
  assign bus.overflow       = overflow_q;
  assign bus.precision_lost = prec_lost_q;
  assign bus.result_full    = full_q;

endmodule
